// File: rtl/s3g_tx_arbiter.sv
// ============================================================================
// s3g_tx_arbiter
// ----------------------------------------------------------------------------
// Shares the single s3g_tx packet framer between two packet sources:
//   requester 0 : executor reply path
//   requester 1 : asynchronous event / status-report path
// A winning request is latched, the framer write is sequenced through the
// framer's busy handshake, and an ack (sent) or err (rejected / timed out)
// pulse is returned to the owning requester. Ties are resolved round-robin.
//
// Optional feature (macro TX_ARB_TIMEOUT_EN):
//   When defined, a watchdog counts cycles since the framer strobe. If the
//   framer has not completed after TIMEOUT_CYCLES, the owner gets err instead
//   of ack and the sticky output o_timeout_seen is set (cleared by i_rst).
//   When undefined, the arbiter waits indefinitely and has no o_timeout_seen.
//
// Ports:
//   i_clk             system clock
//   i_rst             synchronous active-high reset
//   i_req0/i_req1     request, held until ack/err
//   i_len0/i_len1     payload length in bytes
//   i_data0/i_data1   payload, byte k at [8k+7:8k]
//   o_ack0/o_ack1     one-cycle pulse: packet fully sent
//   o_err0/o_err1     one-cycle pulse: request rejected or timed out
//   i_tx_busy         framer busy flag
//   o_tx_packet_wr    one-cycle write strobe to the framer
//   o_tx_payload_len  latched length to the framer
//   o_tx_data         latched payload, framer buf k = o_tx_data[8k+7:8k]
//   o_owner           current or last granted requester
//   o_active          high from grant until the transaction is released
//   o_timeout_seen    sticky watchdog flag (TX_ARB_TIMEOUT_EN only)
// ============================================================================
module s3g_tx_arbiter #(
   parameter int MAX_LEN        = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_req0,
   input  logic [7:0]   i_len0,
   input  logic [127:0] i_data0,
   output logic         o_ack0,
   output logic         o_err0,
   input  logic         i_req1,
   input  logic [7:0]   i_len1,
   input  logic [127:0] i_data1,
   output logic         o_ack1,
   output logic         o_err1,
   input  logic         i_tx_busy,
   output logic         o_tx_packet_wr,
   output logic [7:0]   o_tx_payload_len,
   output logic [127:0] o_tx_data,
   output logic         o_owner,
`ifdef TX_ARB_TIMEOUT_EN
   output logic         o_active,
   output logic         o_timeout_seen
`else
   output logic         o_active
`endif
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   // The framer holds 16 bytes; a longer MAX_LEN could never be sent, and the
   // watchdog compare needs at least two cycles of headroom.
   generate
      if (MAX_LEN > 16 || MAX_LEN < 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
         $error("s3g_tx_arbiter: MAX_LEN must be 0..16 and TIMEOUT_CYCLES >= 2");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t         r_state;
   logic           r_last_served;
   logic           r_owner;
   logic           r_active;
   logic           r_tx_packet_wr;
   logic [7:0]     r_tx_payload_len;
   logic [127:0]   r_tx_data;
   logic           r_ack0;
   logic           r_ack1;
   logic           r_err0;
   logic           r_err1;

   // -------------------------------------------------------------------------
   // Combinational signals
   // -------------------------------------------------------------------------
   state_t         w_state_nxt;
   logic           w_pulse_out;
   logic           w_can_grant;
   logic           w_grant_valid;
   logic           w_grant_idx;
   logic [7:0]     w_grant_len;
   logic [127:0]   w_grant_data;
   logic           w_len_bad;
   logic           w_accept;
   logic           w_reject;
   logic           w_done;
   logic           w_timeout;
   logic           w_release_err;

   logic           w_last_served_nxt;
   logic           w_owner_nxt;
   logic           w_active_nxt;
   logic           w_tx_packet_wr_nxt;
   logic [7:0]     w_tx_payload_len_nxt;
   logic [127:0]   w_tx_data_nxt;
   logic           w_ack0_nxt;
   logic           w_ack1_nxt;
   logic           w_err0_nxt;
   logic           w_err1_nxt;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   // While an ack/err pulse is on the outputs the requester has not yet had a
   // chance to drop req, so nobody is granted in that cycle; this also keeps
   // a still-high req from being re-granted on its own ack.
   assign w_pulse_out   = r_ack0 | r_ack1 | r_err0 | r_err1;
   assign w_can_grant   = (r_state == S_IDLE) && !i_tx_busy && !w_pulse_out;
   assign w_grant_valid = w_can_grant && (i_req0 || i_req1);

   // Both requesting: pick the one not served last. Otherwise the lone one.
   assign w_grant_idx   = (i_req0 && i_req1) ? ~r_last_served : i_req1;
   assign w_grant_len   = w_grant_idx ? i_len1  : i_len0;
   assign w_grant_data  = w_grant_idx ? i_data1 : i_data0;
   assign w_len_bad     = (w_grant_len > 8'(MAX_LEN));
   assign w_accept      = w_grant_valid && !w_len_bad;
   assign w_reject      = w_grant_valid &&  w_len_bad;

   // Framer has finished: busy seen high, now low again.
   assign w_done        = (r_state == S_WAIT_DONE) && !i_tx_busy;

   // A completion in the same cycle as the watchdog expiring wins.
   assign w_release_err = w_timeout && !w_done;

   // -------------------------------------------------------------------------
   // Optional watchdog
   // -------------------------------------------------------------------------
`ifdef TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout_seen;

   // r_cnt holds the number of cycles since the strobe (0 in the strobe
   // cycle), so the err pulse lands exactly TIMEOUT_CYCLES after the strobe.
   assign w_timeout = ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt          <= '0;
         r_timeout_seen <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt <= '0;
         end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_release_err) begin
            r_timeout_seen <= 1'b1;
         end
      end
   end

   assign o_timeout_seen = r_timeout_seen;
`else
   assign w_timeout = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: every clocked assignment uses <= so all registers update from the
   // same pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   // NOTE: each always_comb output is given a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_START;
         end
         S_START: begin
            w_state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (w_timeout)      w_state_nxt = S_IDLE;
            else if (i_tx_busy) w_state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (w_done || w_timeout) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output logic (next values of the registered outputs)
   // -------------------------------------------------------------------------
   always_comb begin
      w_last_served_nxt    = r_last_served;
      w_owner_nxt          = r_owner;
      w_active_nxt         = r_active;
      w_tx_packet_wr_nxt   = 1'b0;
      w_tx_payload_len_nxt = r_tx_payload_len;
      w_tx_data_nxt        = r_tx_data;
      w_ack0_nxt           = 1'b0;
      w_ack1_nxt           = 1'b0;
      w_err0_nxt           = 1'b0;
      w_err1_nxt           = 1'b0;

      if (w_accept) begin
         // Payload registers change only here, so they stay stable from the
         // strobe through the whole transaction and until the next grant.
         w_tx_payload_len_nxt = w_grant_len;
         w_tx_data_nxt        = w_grant_data;
         w_owner_nxt          = w_grant_idx;
         w_active_nxt         = 1'b1;
         w_tx_packet_wr_nxt   = 1'b1;
      end

      if (w_reject) begin
         // Oversize request: answered immediately, framer untouched.
         w_last_served_nxt = w_grant_idx;
         w_err0_nxt        = ~w_grant_idx;
         w_err1_nxt        =  w_grant_idx;
      end

      if (w_done) begin
         w_active_nxt      = 1'b0;
         w_last_served_nxt = r_owner;
         w_ack0_nxt        = ~r_owner;
         w_ack1_nxt        =  r_owner;
      end else if (w_release_err) begin
         w_active_nxt      = 1'b0;
         w_last_served_nxt = r_owner;
         w_err0_nxt        = ~r_owner;
         w_err1_nxt        =  r_owner;
      end
   end

   // -------------------------------------------------------------------------
   // Output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_served    <= 1'b1;
         r_owner          <= 1'b0;
         r_active         <= 1'b0;
         r_tx_packet_wr   <= 1'b0;
         r_tx_payload_len <= '0;
         r_tx_data        <= '0;
         r_ack0           <= 1'b0;
         r_ack1           <= 1'b0;
         r_err0           <= 1'b0;
         r_err1           <= 1'b0;
      end else begin
         r_last_served    <= w_last_served_nxt;
         r_owner          <= w_owner_nxt;
         r_active         <= w_active_nxt;
         r_tx_packet_wr   <= w_tx_packet_wr_nxt;
         r_tx_payload_len <= w_tx_payload_len_nxt;
         r_tx_data        <= w_tx_data_nxt;
         r_ack0           <= w_ack0_nxt;
         r_ack1           <= w_ack1_nxt;
         r_err0           <= w_err0_nxt;
         r_err1           <= w_err1_nxt;
      end
   end

   assign o_ack0           = r_ack0;
   assign o_ack1           = r_ack1;
   assign o_err0           = r_err0;
   assign o_err1           = r_err1;
   assign o_tx_packet_wr   = r_tx_packet_wr;
   assign o_tx_payload_len = r_tx_payload_len;
   assign o_tx_data        = r_tx_data;
   assign o_owner          = r_owner;
   assign o_active         = r_active;

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// ============================================================================
// tb_s3g_tx_arbiter
// ----------------------------------------------------------------------------
// Directed bench for s3g_tx_arbiter. A small framer model raises busy a
// programmable number of cycles after each strobe; a monitor records every
// strobe and every ack/err pulse. Inputs are driven and outputs sampled on
// the falling clock edge.
// ============================================================================
module tb_s3g_tx_arbiter;

   localparam int TO_CYCLES = 50;

   logic         clk;
   logic         rst;
   logic         req0, req1;
   logic [7:0]   len0, len1;
   logic [127:0] data0, data1;
   logic         ack0, ack1, err0, err1;
   logic         tx_busy;
   logic         tx_packet_wr;
   logic [7:0]   tx_payload_len;
   logic [127:0] tx_data;
   logic         owner;
   logic         active;
`ifdef TX_ARB_TIMEOUT_EN
   logic         timeout_seen;
`endif

   // framer model controls
   logic         fw_busy;
   logic         fw_en;
   logic         busy_force;
   int           busy_delay;
   int           busy_len;

   assign tx_busy = fw_busy | busy_force;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // monitor records
   int           wr_owner_q[$];
   int           wr_len_q[$];
   int           wr_cyc_q[$];
   int           wr_active_q[$];
   logic [127:0] wr_data_q[$];
   int n_ack0 = 0, n_ack1 = 0, n_err0 = 0, n_err1 = 0, n_excl = 0;

   s3g_tx_arbiter #(
      .MAX_LEN        (16),
      .TIMEOUT_CYCLES (TO_CYCLES)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_req0           (req0),
      .i_len0           (len0),
      .i_data0          (data0),
      .o_ack0           (ack0),
      .o_err0           (err0),
      .i_req1           (req1),
      .i_len1           (len1),
      .i_data1          (data1),
      .o_ack1           (ack1),
      .o_err1           (err1),
      .i_tx_busy        (tx_busy),
      .o_tx_packet_wr   (tx_packet_wr),
      .o_tx_payload_len (tx_payload_len),
      .o_tx_data        (tx_data),
      .o_owner          (owner),
`ifdef TX_ARB_TIMEOUT_EN
      .o_active         (active),
      .o_timeout_seen   (timeout_seen)
`else
      .o_active         (active)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int owner_at(input int i);
      if (i < wr_owner_q.size()) return wr_owner_q[i];
      return -1;
   endfunction

   function automatic int len_at(input int i);
      if (i < wr_len_q.size()) return wr_len_q[i];
      return -1;
   endfunction

   function automatic int gap_at(input int i);
      if (i + 1 < wr_cyc_q.size()) return wr_cyc_q[i+1] - wr_cyc_q[i];
      return -1;
   endfunction

   // Framer model: busy rises busy_delay cycles after the strobe, lasts busy_len.
   initial begin
      fw_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_packet_wr && fw_en) begin
            repeat (busy_delay) @(negedge clk);
            fw_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            fw_busy = 1'b0;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (tx_packet_wr) begin
         wr_owner_q.push_back(int'(owner));
         wr_len_q.push_back(int'(tx_payload_len));
         wr_cyc_q.push_back(cyc);
         wr_active_q.push_back(int'(active));
         wr_data_q.push_back(tx_data);
      end
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
      if (err0) n_err0++;
      if (err1) n_err1++;
      if (int'(ack0) + int'(ack1) + int'(err0) + int'(err1) > 1) n_excl++;
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Raise a request at the current falling edge, wait for its ack/err,
   // drop req in the cycle the pulse is seen. kind: 0 none, 1 ack, 2 err.
   task automatic do_req(input int idx, input logic [7:0] len, input logic [127:0] data,
                         output int lat, output int kind);
      if (idx == 0) begin req0 = 1'b1; len0 = len; data0 = data; end
      else          begin req1 = 1'b1; len1 = len; data1 = data; end
      lat  = 0;
      kind = 0;
      while (kind == 0 && lat < 2000) begin
         @(negedge clk);
         lat++;
         if ((idx == 0) ? ack0 : ack1)      kind = 1;
         else if ((idx == 0) ? err0 : err1) kind = 2;
      end
      if (idx == 0) req0 = 1'b0;
      else          req1 = 1'b0;
   endtask

   // Both requesters raised together; each drops when its ack is seen.
   task automatic do_tie(input logic [7:0] l0, input logic [7:0] l1, output logic [1:0] done);
      int n;
      req0 = 1'b1; len0 = l0; data0 = 128'h1111;
      req1 = 1'b1; len1 = l1; data1 = 128'h2222;
      done = 2'b00;
      n    = 0;
      while (done != 2'b11 && n < 500) begin
         @(negedge clk);
         n++;
         if (ack0) begin done[0] = 1'b1; req0 = 1'b0; end
         if (ack1) begin done[1] = 1'b1; req1 = 1'b0; end
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      int          lat, kind, base, n;
      int          snap_ack, snap_wr;
      logic [1:0]  done;
      logic        seen;

      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      len0 = '0; len1 = '0; data0 = '0; data1 = '0;
      fw_en = 1'b1; busy_force = 1'b0; busy_delay = 2; busy_len = 20;
      do_reset();

      // ---- reset state ----
      check("reset_ctl", {tx_packet_wr, tx_payload_len, owner, active, ack0, ack1, err0, err1}, '0);
      check("reset_data", tx_data, '0);

      // ---- basic send: len 5, byte0 A5, busy +2 for 20 cycles ----
      base = wr_owner_q.size();
      do_req(0, 8'd5, 128'h0F0E0D0C0B0A090807060504030201A5, lat, kind);
      check("basic_kind", kind, 1);
      check("basic_latency", lat, 24);
      check("basic_strobes", wr_owner_q.size() - base, 1);
      check("basic_len", len_at(base), 5);
      if (base < wr_data_q.size()) begin
         check("basic_byte0", wr_data_q[base][7:0], 8'hA5);
         check("basic_active_at_wr", wr_active_q[base], 1);
      end else begin
         check("basic_strobe_seen", 0, 1);
      end
      check("basic_active_after", active, 0);
      check("basic_hold_len", tx_payload_len, 8'd5);
      check("basic_err_count", n_err0 + n_err1, 0);
      repeat (2) @(negedge clk);

      // ---- tie after reset: 0 first then 1; short busy (immediate handoff) ----
      do_reset();
      busy_delay = 1; busy_len = 1;
      base = wr_owner_q.size();
      do_tie(8'd3, 8'd4, done);
      check("tie1_done", done, 2'b11);
      check("tie1_first", owner_at(base), 0);
      check("tie1_second", owner_at(base + 1), 1);
      check("tie1_len_second", len_at(base + 1), 4);
      check("tie1_strobe_gap", gap_at(base), 5);
      repeat (2) @(negedge clk);

      // ---- requester 0 served alone, then a tie goes to requester 1 ----
      do_req(0, 8'd2, 128'h33, lat, kind);
      check("rr_pre_kind", kind, 1);
      repeat (2) @(negedge clk);
      base = wr_owner_q.size();
      do_tie(8'd6, 8'd7, done);
      check("tie2_done", done, 2'b11);
      check("tie2_first", owner_at(base), 1);
      check("tie2_second", owner_at(base + 1), 0);
      repeat (2) @(negedge clk);

      // ---- oversize request: err1 next cycle, no strobe ----
      snap_wr = wr_owner_q.size();
      do_req(1, 8'd17, 128'h44, lat, kind);
      check("rej_kind", kind, 2);
      check("rej_latency", lat, 1);
      check("rej_active", active, 0);
      repeat (3) @(negedge clk);
      check("rej_no_strobe", wr_owner_q.size() - snap_wr, 0);

      // ---- boundary: len = MAX_LEN accepted ----
      base = wr_owner_q.size();
      do_req(0, 8'd16, 128'h55, lat, kind);
      check("max_len_kind", kind, 1);
      check("max_len_len", len_at(base), 16);
      repeat (2) @(negedge clk);

      // ---- empty packet on requester 1 ----
      busy_delay = 2; busy_len = 3;
      base = wr_owner_q.size();
      do_req(1, 8'd0, 128'h66, lat, kind);
      check("len0_kind", kind, 1);
      check("len0_len", len_at(base), 0);
      check("len0_owner", owner_at(base), 1);
      check("len0_latency", lat, 7);
      repeat (2) @(negedge clk);

      // ---- busy high in IDLE blocks grants ----
      busy_force = 1'b1;
      snap_wr = wr_owner_q.size();
      req0 = 1'b1; len0 = 8'd2; data0 = 128'h77;
      repeat (6) @(negedge clk);
      check("busy_block_strobes", wr_owner_q.size() - snap_wr, 0);
      check("busy_block_active", active, 0);
      busy_force = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (ack0) seen = 1'b1;
      end
      req0 = 1'b0;
      check("busy_block_release", seen, 1'b1);
      repeat (2) @(negedge clk);

      // ---- reset while in WAIT_DONE ----
      busy_delay = 2; busy_len = 20;
      snap_wr = wr_owner_q.size();
      req1 = 1'b1; len1 = 8'd7; data1 = 128'h88;
      n = 0;
      while (wr_owner_q.size() == snap_wr && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_strobe", wr_owner_q.size() - snap_wr, 1);
      repeat (5) @(negedge clk);
      check("rst_mid_active_before", active, 1);
      rst = 1'b1; req1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_ctl", {tx_packet_wr, tx_payload_len, owner, active, ack0, ack1, err0, err1}, '0);
      check("rst_mid_data", tx_data, '0);
      snap_ack = n_ack0 + n_ack1 + n_err0 + n_err1;
      snap_wr  = wr_owner_q.size();
      repeat (30) @(negedge clk);
      check("rst_mid_no_pulse", n_ack0 + n_ack1 + n_err0 + n_err1 - snap_ack, 0);
      check("rst_mid_no_strobe", wr_owner_q.size() - snap_wr, 0);
      do_req(0, 8'd9, 128'h99, lat, kind);
      check("rst_after_kind", kind, 1);
      check("rst_after_latency", lat, 24);
      repeat (2) @(negedge clk);

`ifdef TX_ARB_TIMEOUT_EN
      // ---- watchdog: framer never goes busy ----
      check("to_seen_before", timeout_seen, 1'b0);
      fw_en = 1'b0;
      do_req(0, 8'd4, 128'hAA, lat, kind);
      check("to_kind", kind, 2);
      check("to_latency", lat, 1 + TO_CYCLES);
      check("to_seen", timeout_seen, 1'b1);
      check("to_active", active, 1'b0);
      fw_en = 1'b1;
      repeat (2) @(negedge clk);
      do_req(1, 8'd1, 128'hBB, lat, kind);
      check("to_recover_kind", kind, 1);
      check("to_seen_sticky", timeout_seen, 1'b1);
`endif

      check("pulse_exclusive", n_excl, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
